// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - Writeback arbiter merging buffered ALU results and MULT results onto the CDB.
module cdb_arbiter #(
  parameter int DEPTH = 4,
  parameter int LANES = 8,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   Valid_ALU_ARB,
  input  logic [7:0]             ActiveMask_ALU_ARB,
  input  logic [2:0]             WarpID_ALU_ARB,
  input  logic [31:0]            Instr_ALU_ARB,
  input  logic [4:0]             Dst_ALU_ARB,
  input  logic [LANES*WIDTH-1:0] Data_ALU_ARB,
  input  logic [1:0]             ScbID_ALU_ARB,

  input  logic                   Valid_MULT_ARB,
  input  logic [7:0]             ActiveMask_MULT_ARB,
  input  logic [2:0]             WarpID_MULT_ARB,
  input  logic [31:0]            Instr_MULT_ARB,
  input  logic [4:0]             Dst_MULT_ARB,
  input  logic [LANES*WIDTH-1:0] Data_MULT_ARB,
  input  logic [1:0]             ScbID_MULT_ARB,
  output logic                   Ready_ARB_MULT,

  output logic                   Stall_ARB_OC,

  output logic                   Valid_ARB_CDB,
  output logic [7:0]             ActiveMask_ARB_CDB,
  output logic [2:0]             WarpID_ARB_CDB,
  output logic [31:0]            Instr_ARB_CDB,
  output logic [4:0]             Dst_ARB_CDB,
  output logic [LANES*WIDTH-1:0] Data_ARB_CDB,
  output logic [1:0]             ScbID_ARB_CDB,

  output logic                   Overflow_Err
);

  localparam int DW = LANES * WIDTH;
  localparam int EW = 8 + 3 + 32 + 5 + DW + 2;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {
    GNT_ALU  = 1'b0,
    GNT_MULT = 1'b1
  } gnt_e;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  gnt_e          last_grant_q, last_grant_d;
  logic          overflow_q, overflow_d;
  logic          cdb_valid_q, cdb_valid_d;
  logic [EW-1:0] cdb_q, cdb_d;

  logic [EW-1:0] alu_in, mult_in, alu_cand;
  logic          fifo_nonempty, fifo_full;
  logic          alu_req, mult_req;
  logic          grant_alu, grant_mult;
  logic          pop, push, drop, push_wr;

  assign alu_in  = {ActiveMask_ALU_ARB, WarpID_ALU_ARB, Instr_ALU_ARB,
                    Dst_ALU_ARB, Data_ALU_ARB, ScbID_ALU_ARB};
  assign mult_in = {ActiveMask_MULT_ARB, WarpID_MULT_ARB, Instr_MULT_ARB,
                    Dst_MULT_ARB, Data_MULT_ARB, ScbID_MULT_ARB};

  always_comb begin
    fifo_nonempty = (count_q != '0);
    fifo_full     = (count_q == CW'(DEPTH));
    // With an empty FIFO the incoming ALU result is the candidate (cut-through).
    alu_cand      = fifo_nonempty ? mem_q[rd_ptr_q] : alu_in;
    alu_req       = fifo_nonempty || Valid_ALU_ARB;
    mult_req      = Valid_MULT_ARB;

    grant_alu     = alu_req  && (!mult_req || (last_grant_q == GNT_MULT));
    grant_mult    = mult_req && (!alu_req  || (last_grant_q == GNT_ALU));

    pop           = grant_alu && fifo_nonempty;
    push          = Valid_ALU_ARB && !(grant_alu && !fifo_nonempty);
    drop          = push && fifo_full && !pop;
    push_wr       = push && !drop;

    count_d       = count_q + CW'(push_wr) - CW'(pop);
    rd_ptr_d      = rd_ptr_q + AW'(pop);
    wr_ptr_d      = wr_ptr_q + AW'(push_wr);
    overflow_d    = overflow_q || drop;

    last_grant_d  = last_grant_q;
    if (grant_alu) begin
      last_grant_d = GNT_ALU;
    end else if (grant_mult) begin
      last_grant_d = GNT_MULT;
    end

    // Fields hold their last broadcast value on idle cycles.
    cdb_valid_d   = grant_alu || grant_mult;
    cdb_d         = cdb_q;
    if (grant_alu) begin
      cdb_d = alu_cand;
    end else if (grant_mult) begin
      cdb_d = mult_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      last_grant_q <= GNT_MULT;
      overflow_q   <= 1'b0;
      cdb_valid_q  <= 1'b0;
      cdb_q        <= '0;
    end else begin
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      last_grant_q <= last_grant_d;
      overflow_q   <= overflow_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_q        <= cdb_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push_wr) begin
      mem_q[wr_ptr_q] <= alu_in;
    end
  end

  assign Ready_ARB_MULT = grant_mult;
  // One spare slot absorbs the ALU result already in flight when stall rises.
  assign Stall_ARB_OC   = (count_q >= CW'(DEPTH - 1));
  assign Overflow_Err   = overflow_q;
  assign Valid_ARB_CDB  = cdb_valid_q;
  assign {ActiveMask_ARB_CDB, WarpID_ARB_CDB, Instr_ARB_CDB,
          Dst_ARB_CDB, Data_ARB_CDB, ScbID_ARB_CDB} = cdb_q;

endmodule
